// File: rtl/mine_sequencer.sv
// Double-SHA256 proof-of-work job controller: hashes the header midstate once per job, then
// sweeps a nonce window on an external iterative SHA256 core and records the first hit.
module mine_sequencer #(
    parameter logic [31:0] NONCE_STEP   = 32'd1,
    parameter bit          STOP_ON_FIND = 1'b1,
    parameter int          CNT_W        = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [639:0]     header,
    input  logic [31:0]      nonce_first,
    input  logic [31:0]      nonce_count,
    input  logic [255:0]     target,
    output logic [511:0]     sha_block,
    output logic [255:0]     sha_hin,
    output logic             sha_start,
    input  logic             sha_done,
    input  logic [255:0]     sha_hout,
    output logic             busy,
    output logic             found,
    output logic [31:0]      found_nonce,
    output logic [255:0]     found_hash,
    output logic             exhausted,
    output logic [CNT_W-1:0] hash_count
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_M1_ISSUE = 4'd1;
    localparam logic [3:0] S_M1_WAIT  = 4'd2;
    localparam logic [3:0] S_B2_ISSUE = 4'd3;
    localparam logic [3:0] S_B2_WAIT  = 4'd4;
    localparam logic [3:0] S_F_ISSUE  = 4'd5;
    localparam logic [3:0] S_F_WAIT   = 4'd6;
    localparam logic [3:0] S_CHECK    = 4'd7;
    localparam logic [3:0] S_FOUND    = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;

    localparam logic [255:0] SHA_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    logic [3:0]       state_q, state_d;
    logic [607:0]     header_q, header_d;
    logic [255:0]     target_q, target_d;
    logic [31:0]      cur_nonce_q, cur_nonce_d;
    logic [32:0]      remaining_q, remaining_d;
    logic [255:0]     midstate_q, midstate_d;
    logic [255:0]     d1_q, d1_d;
    logic [255:0]     hrev_q, hrev_d;
    logic             found_q, found_d;
    logic [31:0]      found_nonce_q, found_nonce_d;
    logic [255:0]     found_hash_q, found_hash_d;
    logic             exhausted_q, exhausted_d;
    logic [CNT_W-1:0] hash_count_q, hash_count_d;
    logic [255:0]     hout_rev;
    logic             new_hit;
    logic             unused_nonce_field;

    // The nonce field of the incoming header is always overwritten, so it is never stored.
    assign unused_nonce_field = ^header[31:0];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_byte_rev
            assign hout_rev[8*gi +: 8] = sha_hout[255-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        header_d      = header_q;
        target_d      = target_q;
        cur_nonce_d   = cur_nonce_q;
        remaining_d   = remaining_q;
        midstate_d    = midstate_q;
        d1_d          = d1_q;
        hrev_d        = hrev_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        exhausted_d   = exhausted_q;
        hash_count_d  = hash_count_q;
        sha_start     = 1'b0;
        sha_block     = '0;
        sha_hin       = '0;
        new_hit       = 1'b0;

        case (state_q)
            S_IDLE, S_FOUND, S_DONE: begin
                if (start) begin
                    header_d     = header[639:32];
                    target_d     = target;
                    cur_nonce_d  = nonce_first;
                    remaining_d  = (nonce_count == 32'd0) ? 33'h1_0000_0000 : {1'b0, nonce_count};
                    found_d      = 1'b0;
                    exhausted_d  = 1'b0;
                    hash_count_d = '0;
                    state_d      = S_M1_ISSUE;
                end
            end
            S_M1_ISSUE: begin
                sha_start = 1'b1;
                sha_block = header_q[607:96];
                sha_hin   = SHA_IV;
                state_d   = S_M1_WAIT;
            end
            S_M1_WAIT: begin
                if (sha_done) begin
                    midstate_d = sha_hout;
                    state_d    = S_B2_ISSUE;
                end
            end
            S_B2_ISSUE: begin
                sha_start = 1'b1;
                sha_block = {header_q[95:0], cur_nonce_q, 1'b1, 319'b0, 64'd640};
                sha_hin   = midstate_q;
                state_d   = S_B2_WAIT;
            end
            S_B2_WAIT: begin
                if (sha_done) begin
                    d1_d    = sha_hout;
                    state_d = S_F_ISSUE;
                end
            end
            S_F_ISSUE: begin
                sha_start = 1'b1;
                sha_block = {d1_q, 1'b1, 191'b0, 64'd256};
                sha_hin   = SHA_IV;
                state_d   = S_F_WAIT;
            end
            S_F_WAIT: begin
                if (sha_done) begin
                    hrev_d  = hout_rev;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                new_hit = (hrev_q < target_q) && !found_q;
                if (!(&hash_count_q)) begin
                    hash_count_d = hash_count_q + CNT_W'(1);
                end
                if (new_hit) begin
                    found_d       = 1'b1;
                    found_nonce_d = cur_nonce_q;
                    found_hash_d  = hrev_q;
                end
                if (new_hit && STOP_ON_FIND) begin
                    state_d = S_FOUND;
                end else begin
                    remaining_d = remaining_q - 33'd1;
                    if (remaining_q == 33'd1) begin
                        exhausted_d = !(found_q || new_hit);
                        state_d     = S_DONE;
                    end else begin
                        cur_nonce_d = cur_nonce_q + NONCE_STEP;
                        state_d     = S_B2_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            header_q      <= '0;
            target_q      <= '0;
            cur_nonce_q   <= '0;
            remaining_q   <= '0;
            midstate_q    <= '0;
            d1_q          <= '0;
            hrev_q        <= '0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            exhausted_q   <= 1'b0;
            hash_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            header_q      <= header_d;
            target_q      <= target_d;
            cur_nonce_q   <= cur_nonce_d;
            remaining_q   <= remaining_d;
            midstate_q    <= midstate_d;
            d1_q          <= d1_d;
            hrev_q        <= hrev_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
            exhausted_q   <= exhausted_d;
            hash_count_q  <= hash_count_d;
        end
    end

    assign busy        = !((state_q == S_IDLE) || (state_q == S_FOUND) || (state_q == S_DONE));
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;
    assign exhausted   = exhausted_q;
    assign hash_count  = hash_count_q;

endmodule

// File: tb/tb_mine_sequencer.sv
// Bench for mine_sequencer: three instances (step 1 / stop, step 1 / continue, step 4 / stop)
// share a behavioural SHA256 core model that checks every issued compression against a scoreboard.
module tb_mine_sequencer;

    localparam int N = 3;
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [639:0] GEN_HDR = {32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
    localparam logic [255:0] GEN_HASH =
        256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] GEN_TGT = 256'hffff << 208;

    typedef struct {
        logic [511:0] blk;
        logic [255:0] hin;
    } issue_t;

    typedef struct {
        int           inst;
        logic [31:0]  nfirst;
        logic [31:0]  ncount;
        logic [255:0] tgt;
        int           lat;
        bit           poke;
        bit           exp_found;
        logic [31:0]  exp_fnonce;
        int           exp_count;
        bit           exp_exh;
        int           exp_pulses;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   start_v;
    logic [639:0]   header_i;
    logic [31:0]    nonce_first_i;
    logic [31:0]    nonce_count_i;
    logic [255:0]   target_i;
    logic [511:0]   sha_block_v [N];
    logic [255:0]   sha_hin_v [N];
    logic [N-1:0]   sha_start_v;
    logic [N-1:0]   sha_done_v;
    logic [255:0]   sha_hout_v [N];
    logic [N-1:0]   busy_v;
    logic [N-1:0]   found_v;
    logic [31:0]    found_nonce_v [N];
    logic [255:0]   found_hash_v [N];
    logic [N-1:0]   exh_v;
    logic [47:0]    hash_count_v [N];

    issue_t exp_q[$];
    int     pulses [N];
    int     lat = 1;
    int     n_cmp = 0;
    int     n_fail = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            mine_sequencer #(
                .NONCE_STEP  ((gi == 2) ? 32'd4 : 32'd1),
                .STOP_ON_FIND((gi == 1) ? 1'b0 : 1'b1),
                .CNT_W       (48)
            ) u_dut (
                .clock      (clk),
                .reset      (rst),
                .start      (start_v[gi]),
                .header     (header_i),
                .nonce_first(nonce_first_i),
                .nonce_count(nonce_count_i),
                .target     (target_i),
                .sha_block  (sha_block_v[gi]),
                .sha_hin    (sha_hin_v[gi]),
                .sha_start  (sha_start_v[gi]),
                .sha_done   (sha_done_v[gi]),
                .sha_hout   (sha_hout_v[gi]),
                .busy       (busy_v[gi]),
                .found      (found_v[gi]),
                .found_nonce(found_nonce_v[gi]),
                .found_hash (found_hash_v[gi]),
                .exhausted  (exh_v[gi]),
                .hash_count (hash_count_v[gi])
            );
        end
    endgenerate

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Behavioural core: answers each sha_start after lat cycles and checks it against the scoreboard.
    initial begin
        int     cnt [N];
        bit     pend [N];
        logic [255:0] res [N];
        issue_t e;
        sha_done_v = '0;
        for (int i = 0; i < N; i++) begin
            sha_hout_v[i] = '0;
            pend[i] = 1'b0;
            cnt[i] = 0;
            res[i] = '0;
            pulses[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                sha_done_v[i] = 1'b0;
                if (pend[i]) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        sha_done_v[i] = 1'b1;
                        sha_hout_v[i] = res[i];
                        pend[i] = 1'b0;
                    end
                end
                if (sha_start_v[i] === 1'b1) begin
                    pulses[i]++;
                    chk($sformatf("inst%0d_start_while_pending", i), 512'(pend[i]), 512'(0));
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL inst%0d_extra_sha_start: got pulse %0d, required none", i, pulses[i]);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("inst%0d_sha_block_p%0d", i, pulses[i]), sha_block_v[i], e.blk);
                        chk($sformatf("inst%0d_sha_hin_p%0d", i, pulses[i]), 512'(sha_hin_v[i]), 512'(e.hin));
                    end
                    res[i] = sha_compress(sha_hin_v[i], sha_block_v[i]);
                    pend[i] = 1'b1;
                    cnt[i] = lat;
                end
            end
        end
    end

    task automatic push_expected(input logic [31:0] nfirst, input logic [31:0] step, input int n_att);
        logic [255:0] mid, d1;
        logic [511:0] b2;
        logic [31:0]  nonce;
        mid = sha_compress(IV, GEN_HDR[639:128]);
        exp_q.delete();
        exp_q.push_back('{GEN_HDR[639:128], IV});
        nonce = nfirst;
        for (int k = 0; k < n_att; k++) begin
            b2 = {GEN_HDR[127:32], nonce, 1'b1, 319'b0, 64'd640};
            d1 = sha_compress(mid, b2);
            exp_q.push_back('{b2, mid});
            exp_q.push_back('{{d1, 1'b1, 191'b0, 64'd256}, IV});
            nonce = nonce + step;
        end
    endtask

    task automatic run_job(input vec_t v, input int idx);
        int inst;
        bit timed_out;
        inst = v.inst;
        push_expected(v.nfirst, (inst == 2) ? 32'd4 : 32'd1, v.exp_count);
        lat = v.lat;
        pulses[inst] = 0;
        header_i = GEN_HDR;
        nonce_first_i = v.nfirst;
        nonce_count_i = v.ncount;
        target_i = v.tgt;
        start_v[inst] = 1'b1;
        tick();
        start_v[inst] = 1'b0;
        header_i = ~GEN_HDR;
        nonce_first_i = ~v.nfirst;
        nonce_count_i = v.ncount + 32'd7;
        target_i = ~v.tgt;
        timed_out = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            start_v[inst] = v.poke && (c == 2);
            tick();
            if (!busy_v[inst]) begin
                timed_out = 1'b0;
                break;
            end
        end
        start_v[inst] = 1'b0;
        chk($sformatf("v%0d_timeout", idx), 512'(timed_out), 512'(0));
        chk($sformatf("v%0d_sha_start_pulses", idx), 512'(pulses[inst]), 512'(v.exp_pulses));
        chk($sformatf("v%0d_scoreboard_left", idx), 512'(exp_q.size()), 512'(0));
        chk($sformatf("v%0d_found", idx), 512'(found_v[inst]), 512'(v.exp_found));
        chk($sformatf("v%0d_exhausted", idx), 512'(exh_v[inst]), 512'(v.exp_exh));
        chk($sformatf("v%0d_hash_count", idx), 512'(hash_count_v[inst]), 512'(v.exp_count));
        if (v.exp_found) begin
            chk($sformatf("v%0d_found_nonce", idx), 512'(found_nonce_v[inst]), 512'(v.exp_fnonce));
            chk($sformatf("v%0d_found_hash", idx), 512'(found_hash_v[inst]), 512'(GEN_HASH));
        end
        $display("job v%0d inst%0d first=%h count=%0d lat=%0d -> found=%0d nonce=%h exhausted=%0d hashes=%0d pulses=%0d",
                 idx, inst, v.nfirst, v.ncount, v.lat, found_v[inst], found_nonce_v[inst],
                 exh_v[inst], hash_count_v[inst], pulses[inst]);
        tick();
    endtask

    initial begin
        vec_t vecs [6];
        bit   timed_out;
        vecs[0] = '{0, 32'h1dac2b7a, 32'd5, GEN_TGT, 1, 1'b0, 1'b1, 32'h1dac2b7c, 3, 1'b0, 7};
        vecs[1] = '{1, 32'h1dac2b7a, 32'd5, GEN_TGT, 3, 1'b0, 1'b1, 32'h1dac2b7c, 5, 1'b0, 11};
        vecs[2] = '{0, 32'h1dac2b7a, 32'd5, 256'h0,  2, 1'b0, 1'b0, 32'h0,        5, 1'b1, 11};
        vecs[3] = '{0, 32'hfffffffe, 32'd3, 256'h0,  4, 1'b0, 1'b0, 32'h0,        3, 1'b1, 7};
        vecs[4] = '{2, 32'h1dac2b70, 32'd4, GEN_TGT, 2, 1'b0, 1'b1, 32'h1dac2b7c, 4, 1'b0, 9};
        vecs[5] = '{0, 32'h12345678, 32'd2, 256'h0,  1, 1'b1, 1'b0, 32'h0,        2, 1'b1, 5};

        start_v = '0;
        header_i = '0;
        nonce_first_i = '0;
        nonce_count_i = '0;
        target_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_flags_inst%0d", i),
                512'({busy_v[i], found_v[i], exh_v[i], sha_start_v[i]}), 512'(0));
            chk($sformatf("rst_count_inst%0d", i), 512'(hash_count_v[i]), 512'(0));
            chk($sformatf("rst_sha_bus_inst%0d", i), sha_block_v[i] | 512'(sha_hin_v[i]), 512'(0));
        end

        // Reset while waiting on block two; the core's late sha_done must be ignored.
        push_expected(32'h1dac2b7a, 32'd1, 1);
        void'(exp_q.pop_back());
        lat = 4;
        pulses[0] = 0;
        header_i = GEN_HDR;
        nonce_first_i = 32'h1dac2b7a;
        nonce_count_i = 32'd5;
        target_i = 256'h0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (pulses[0] >= 2) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
        chk("rstseq_reach_b2_wait", 512'(timed_out), 512'(0));
        rst = 1'b1;
        start_v[0] = 1'b1;
        tick();
        rst = 1'b0;
        start_v[0] = 1'b0;
        repeat (12) tick();
        chk("rstseq_no_sha_start", 512'(pulses[0]), 512'(2));
        chk("rstseq_flags", 512'({busy_v[0], found_v[0], exh_v[0], sha_start_v[0]}), 512'(0));
        chk("rstseq_count", 512'(hash_count_v[0]), 512'(0));
        chk("rstseq_sha_bus", sha_block_v[0] | 512'(sha_hin_v[0]), 512'(0));
        chk("rstseq_scoreboard_left", 512'(exp_q.size()), 512'(0));
        $display("reset in B2_WAIT: busy=%0d found=%0d hashes=%0d pulses=%0d",
                 busy_v[0], found_v[0], hash_count_v[0], pulses[0]);

        for (int k = 0; k < 6; k++) run_job(vecs[k], k);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
